// File: rtl/branch_checkpoint_scheduler_pkg.sv
// Shared pipeline definitions for the branch checkpoint scheduler: default
// checkpoint count, checkpoint index type and recovery FSM states.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

package branch_checkpoint_scheduler_pkg;

    localparam int NUM_CKPT_DEFAULT = 4;

    typedef logic [$clog2(NUM_CKPT_DEFAULT)-1:0] ckpt_id_t;

    typedef enum logic [0:0] {
        ST_NORMAL  = 1'b0,
        ST_RECOVER = 1'b1
    } bcs_state_e;

endpackage

// File: rtl/branch_checkpoint_scheduler_age_matrix.sv
// Relative age tracking between checkpoints: older[i][j] = 1 means checkpoint i
// was allocated before checkpoint j. Provides oldest-of-set and younger masks.
module ckpt_age_matrix #(
    parameter int N = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_allocEn,
    input  logic [$clog2(N)-1:0] i_allocId,
    input  logic [N-1:0]         i_valid,
    input  logic [N-1:0]         i_cand,
    output logic [N-1:0]         o_oldest,
    output logic [N-1:0]         o_younger
);

    logic [N-1:0] r_older [N];
    logic [N-1:0] w_olderThan [N];

    // A new entry is younger than every currently valid entry and older than none.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N; i++) begin
                r_older[i] <= '0;
            end
        end else if (i_allocEn) begin
            for (int j = 0; j < N; j++) begin
                if (j == int'(i_allocId)) begin
                    r_older[j] <= '0;
                end else begin
                    r_older[j][i_allocId] <= i_valid[j];
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_olderThan[i] = '0;
            for (int j = 0; j < N; j++) begin
                w_olderThan[i][j] = r_older[j][i];
            end
        end
    end

    // A candidate wins when no other candidate is older than it.
    always_comb begin
        o_oldest  = '0;
        o_younger = '0;
        for (int i = 0; i < N; i++) begin
            o_oldest[i] = i_cand[i] & ~(|(i_cand & w_olderThan[i]));
        end
        for (int i = 0; i < N; i++) begin
            if (o_oldest[i]) begin
                o_younger = o_younger | (r_older[i] & i_valid);
            end
        end
    end

endmodule

// File: rtl/branch_checkpoint_scheduler.sv
// Allocates branch checkpoints at dispatch, accepts resolutions and issues a
// one-cycle squash for the oldest mispredicted branch, then waits for recovery.
`ifndef ROB_TAG_LEN
`define ROB_TAG_LEN 6
`endif

module branch_checkpoint_scheduler
    import branch_checkpoint_scheduler_pkg::*;
#(
    parameter int NUM_CKPT = NUM_CKPT_DEFAULT,
    parameter int NUM_RES  = 2
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     alloc_req,
    input  logic [`ROB_TAG_LEN-1:0]                  alloc_rob_tag,
    output logic                                     alloc_gnt,
    output logic [$clog2(NUM_CKPT)-1:0]              alloc_id,
    input  logic [NUM_RES-1:0]                       res_valid,
    input  logic [NUM_RES-1:0][$clog2(NUM_CKPT)-1:0] res_id,
    input  logic [NUM_RES-1:0]                       res_mispredict,
    output logic [NUM_RES-1:0]                       res_ready,
    output logic                                     kill,
    output logic [NUM_CKPT-1:0]                      kill_mask,
    output logic [`ROB_TAG_LEN-1:0]                  kill_rob_tag,
    input  logic                                     recover_done,
    output logic                                     branch_pending,
    output logic                                     ckpt_full
);

    localparam int ID_W  = $clog2(NUM_CKPT);
    localparam int TAG_W = `ROB_TAG_LEN;

    bcs_state_e          r_state;
    logic [NUM_CKPT-1:0] r_valid;
    logic [TAG_W-1:0]    r_tag [NUM_CKPT];
    logic                r_kill;
    logic [NUM_CKPT-1:0] r_killMask;
    logic [TAG_W-1:0]    r_killTag;

    logic [NUM_RES-1:0]  w_resReady;
    logic [NUM_CKPT-1:0] w_mispCand;
    logic [NUM_CKPT-1:0] w_freeMask;
    logic [NUM_CKPT-1:0] w_oldest;
    logic [NUM_CKPT-1:0] w_younger;
    logic [NUM_CKPT-1:0] w_killSet;
    logic [NUM_CKPT-1:0] w_allocMask;
    logic [TAG_W-1:0]    w_winnerTag;
    logic [ID_W-1:0]     w_allocId;
    logic                w_anyMisp;
    logic                w_allocGnt;

    assign w_resReady = {NUM_RES{r_state == ST_NORMAL}};

    // Resolutions naming an invalid checkpoint neither free nor squash.
    always_comb begin
        w_mispCand = '0;
        w_freeMask = '0;
        for (int p = 0; p < NUM_RES; p++) begin
            if (res_valid[p] && w_resReady[p] && r_valid[res_id[p]]) begin
                if (res_mispredict[p]) begin
                    w_mispCand[res_id[p]] = 1'b1;
                end else begin
                    w_freeMask[res_id[p]] = 1'b1;
                end
            end
        end
    end

    assign w_anyMisp = |w_mispCand;
    assign w_killSet = w_anyMisp ? (w_oldest | w_younger) : '0;

    always_comb begin
        w_winnerTag = '0;
        for (int i = 0; i < NUM_CKPT; i++) begin
            if (w_oldest[i]) begin
                w_winnerTag = w_winnerTag | r_tag[i];
            end
        end
    end

    always_comb begin
        w_allocId = '0;
        for (int i = NUM_CKPT - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_allocId = ID_W'(i);
            end
        end
    end

    assign w_allocGnt  = alloc_req && (r_state == ST_NORMAL) && !(&r_valid) && !w_anyMisp;
    assign w_allocMask = w_allocGnt ? (NUM_CKPT'(1) << w_allocId) : '0;

    ckpt_age_matrix #(
        .N(NUM_CKPT)
    ) u_ageMatrix (
        .clock    (clock),
        .reset    (reset),
        .i_allocEn(w_allocGnt),
        .i_allocId(w_allocId),
        .i_valid  (r_valid),
        .i_cand   (w_mispCand),
        .o_oldest (w_oldest),
        .o_younger(w_younger)
    );

    // Correct resolutions younger than the winner are already in the kill set.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_NORMAL;
            r_valid    <= '0;
            r_kill     <= 1'b0;
            r_killMask <= '0;
            r_killTag  <= '0;
        end else begin
            r_valid    <= (r_valid & ~w_freeMask & ~w_killSet) | w_allocMask;
            r_kill     <= w_anyMisp;
            r_killMask <= w_killSet;
            if (w_anyMisp) begin
                r_killTag <= w_winnerTag;
            end
            case (r_state)
                ST_NORMAL:  if (w_anyMisp)    r_state <= ST_RECOVER;
                ST_RECOVER: if (recover_done) r_state <= ST_NORMAL;
                default:                      r_state <= ST_NORMAL;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_allocGnt) begin
            r_tag[w_allocId] <= alloc_rob_tag;
        end
    end

    assign alloc_gnt      = w_allocGnt;
    assign alloc_id       = w_allocId;
    assign res_ready      = w_resReady;
    assign kill           = r_kill;
    assign kill_mask      = r_killMask;
    assign kill_rob_tag   = r_killTag;
    assign branch_pending = |r_valid;
    assign ckpt_full      = &r_valid;

endmodule
